// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM sector sequencer.
// FSM state and transfer direction enums.
package bk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_FINISH
    } bk_state_t;

    typedef enum logic {
        BK_LOAD,
        BK_SAVE
    } bk_mode_t;

endpackage

// File: rtl/bk_edge_sync.sv
// Registered edge detector, qualified by an enable.
// A level already high when ena rises never produces an edge.
module bk_edge_sync (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic din,
    input  logic ena,
    output logic rise,
    output logic fall
);

    logic din_q, din_d;
    logic prev_q, prev_d;
    logic ena_q, ena_d;

    always_comb begin
        din_d  = din;
        prev_d = din_q;
        ena_d  = ena;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            din_q  <= 1'b0;
            prev_q <= 1'b0;
            ena_q  <= 1'b0;
        end else begin
            din_q  <= din_d;
            prev_q <= prev_d;
            ena_q  <= ena_d;
        end
    end

    assign rise = din_q & ~prev_q & ena_q;
    assign fall = ~din_q & prev_q & ena_q;

endmodule

// File: rtl/bk_sector_ctrl.sv
// Save-state / backup-RAM sector sequencer towards hps_io.
// Streams one slot of sectors, with autosave and ack watchdog.
module bk_sector_ctrl
    import bk_pkg::*;
#(
    parameter int          SLOT_BITS = 2,
    parameter int          SECT_BITS = 6,
    parameter int          LBA_W     = 32,
    parameter logic [23:0] HOLDOFF   = 24'd5000000,
    parameter logic [23:0] ACK_TMO   = 24'd16000000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 bk_ena,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic                 autosave_en,
    input  logic                 dirty_set,
    input  logic                 sd_ack,
    output logic [LBA_W-1:0]     sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 bk_loading,
    output logic                 bk_state,
    output logic [SECT_BITS-1:0] sector,
    output logic                 done,
    output logic                 err
);

    localparam int PAD_W = LBA_W - SLOT_BITS - SECT_BITS;

    bk_state_t            state_q, state_d;
    bk_mode_t             mode_q, mode_d;
    logic [SLOT_BITS-1:0] slot_q, slot_d;
    logic [SECT_BITS-1:0] sector_q, sector_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 busy_q, busy_d;
    logic                 loading_q, loading_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 dirty_q, dirty_d;
    logic [23:0]          hold_q, hold_d;
    logic [23:0]          wd_q, wd_d;

    logic load_rise, save_rise;
    logic ack_rise, ack_fall;
    logic unused_fall_ld, unused_fall_sv;
    logic auto_go, wd_expired;

    bk_edge_sync u_load (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (load_req),
        .ena     (bk_ena),
        .rise    (load_rise),
        .fall    (unused_fall_ld)
    );

    bk_edge_sync u_save (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (save_req),
        .ena     (bk_ena),
        .rise    (save_rise),
        .fall    (unused_fall_sv)
    );

    bk_edge_sync u_ack (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (sd_ack),
        .ena     (1'b1),
        .rise    (ack_rise),
        .fall    (ack_fall)
    );

    assign auto_go    = autosave_en & dirty_q & bk_ena
                      & (hold_q == HOLDOFF);
    assign wd_expired = (wd_q >= ACK_TMO - 24'd1);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        slot_d    = slot_q;
        sector_d  = sector_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        busy_d    = busy_q;
        loading_d = loading_q;
        done_d    = 1'b0;
        err_d     = err_q;
        dirty_d   = dirty_q;
        hold_d    = hold_q;
        wd_d      = '0;

        if (dirty_set) begin
            dirty_d = 1'b1;
            hold_d  = '0;
        end else if (hold_q != HOLDOFF) begin
            hold_d = hold_q + 24'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (load_rise | save_rise | auto_go) begin
                    mode_d    = load_rise ? BK_LOAD : BK_SAVE;
                    slot_d    = slot;
                    sector_d  = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    loading_d = load_rise;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_d    = (mode_q == BK_LOAD);
                wr_d    = (mode_q == BK_SAVE);
                state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_WAIT_FALL;
                end else if (wd_expired) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    loading_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
            ST_WAIT_FALL: begin
                if (ack_fall) begin
                    if (&sector_q) begin
                        state_d = ST_FINISH;
                    end else if (!bk_ena) begin
                        // Enable lost: this sector is done, stop cleanly.
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        sector_d = sector_q + SECT_BITS'(1);
                        state_d  = ST_ISSUE;
                    end
                end else if (wd_expired) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    loading_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
            ST_FINISH: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                loading_d = 1'b0;
                if (mode_q == BK_SAVE && !dirty_set) begin
                    dirty_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= BK_LOAD;
            slot_q    <= '0;
            sector_q  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dirty_q   <= 1'b0;
            hold_q    <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            slot_q    <= slot_d;
            sector_q  <= sector_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dirty_q   <= dirty_d;
            hold_q    <= hold_d;
            wd_q      <= wd_d;
        end
    end

    assign sd_lba     = {{PAD_W{1'b0}}, slot_q, sector_q};
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_loading = loading_q;
    assign bk_state   = busy_q;
    assign sector     = sector_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Directed bench for bk_sector_ctrl with an hps_io ack model.
// Expected sector requests are queued at stimulus time.
module tb_bk_sector_ctrl;

    typedef struct packed {
        logic        w;
        logic [31:0] lba;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bk_ena = 1'b0;
    logic [1:0]  slot = '0;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic        autosave_en = 1'b0;
    logic        dirty_set = 1'b0;
    logic        sd_ack = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        bk_loading;
    logic        bk_state;
    logic [5:0]  sector;
    logic        done;
    logic        err;

    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    exp_t exp_q[$];
    bit   hang_en = 1'b0;
    bit   req_prev = 1'b0;

    bk_sector_ctrl #(
        .SLOT_BITS (2),
        .SECT_BITS (6),
        .LBA_W     (32),
        .HOLDOFF   (24'd100),
        .ACK_TMO   (24'd20)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .bk_ena      (bk_ena),
        .slot        (slot),
        .load_req    (load_req),
        .save_req    (save_req),
        .autosave_en (autosave_en),
        .dirty_set   (dirty_set),
        .sd_ack      (sd_ack),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .bk_loading  (bk_loading),
        .bk_state    (bk_state),
        .sector      (sector),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hps_io model: ack each new request, check it against the queue
    always begin
        exp_t e;
        tick();
        if ((sd_rd | sd_wr) && !req_prev) begin
            if (sd_rd) rd_cnt++;
            if (sd_wr) wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 64'(sd_lba), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("req_lba", 64'(sd_lba), 64'(e.lba));
                chk("req_dir", 64'(sd_wr), 64'(e.w));
            end
            if (!(hang_en && sector == 6'd5)) begin
                tick();
                tick();
                sd_ack = 1'b1;
                for (int i = 0; i < 30 && (sd_rd | sd_wr); i++) tick();
                chk("req_drop", 64'(sd_rd | sd_wr), 64'd0);
                tick();
                sd_ack = 1'b0;
            end
        end
        req_prev = sd_rd | sd_wr;
    end

    task automatic push_exp(input logic w, input int s);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            e.w   = w;
            e.lba = 32'(s * 64 + i);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse(input bit ld, input bit sv);
        load_req = ld;
        save_req = sv;
        repeat (3) tick();
        load_req = 1'b0;
        save_req = 1'b0;
    endtask

    task automatic run_xfer(input bit exp_ld, output int n_done,
                            output int ld_bad);
        bit fin = 1'b0;
        n_done = 0;
        ld_bad = 0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            tick();
            if (done) n_done++;
            if (bk_state && bk_loading !== exp_ld) ld_bad++;
            if (!bk_state && bk_loading) ld_bad++;
            if (!bk_state) fin = 1'b1;
        end
        chk("xfer_timeout", 64'(fin), 64'd1);
    endtask

    task automatic wait_wr_sector(input logic [5:0] s);
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (sd_wr && sector == s) found = 1'b1;
            else tick();
        end
        chk("wait_sector", 64'(found), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int nd, lb, r0, w0;

        repeat (3) tick();
        chk("rst_rd", 64'(sd_rd), 64'd0);
        chk("rst_wr", 64'(sd_wr), 64'd0);
        chk("rst_state", 64'(bk_state), 64'd0);
        chk("rst_loading", 64'(bk_loading), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_lba", 64'(sd_lba), 64'd0);
        reset_n = 1'b1;
        bk_ena  = 1'b1;
        repeat (3) tick();

        // save slot 2
        slot = 2'd2;
        push_exp(1'b1, 2);
        r0 = rd_cnt;
        w0 = wr_cnt;
        pulse(1'b0, 1'b1);
        chk("save_busy", 64'(bk_state), 64'd1);
        chk("save_noload", 64'(bk_loading), 64'd0);
        run_xfer(1'b0, nd, lb);
        chk("save_done", 64'(nd), 64'd1);
        chk("save_ld", 64'(lb), 64'd0);
        chk("save_wr", 64'(wr_cnt - w0), 64'd64);
        chk("save_rd", 64'(rd_cnt - r0), 64'd0);
        chk("save_q", 64'(exp_q.size()), 64'd0);
        repeat (5) tick();

        // load slot 1
        slot = 2'd1;
        push_exp(1'b0, 1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        pulse(1'b1, 1'b0);
        chk("load_ld_hi", 64'(bk_loading), 64'd1);
        run_xfer(1'b1, nd, lb);
        chk("load_done", 64'(nd), 64'd1);
        chk("load_ld", 64'(lb), 64'd0);
        chk("load_ld_lo", 64'(bk_loading), 64'd0);
        chk("load_rd", 64'(rd_cnt - r0), 64'd64);
        chk("load_q", 64'(exp_q.size()), 64'd0);
        repeat (5) tick();

        // simultaneous load and save edges
        slot = 2'd0;
        push_exp(1'b0, 0);
        r0 = rd_cnt;
        w0 = wr_cnt;
        pulse(1'b1, 1'b1);
        run_xfer(1'b1, nd, lb);
        chk("both_done", 64'(nd), 64'd1);
        chk("both_rd", 64'(rd_cnt - r0), 64'd64);
        chk("both_wr", 64'(wr_cnt - w0), 64'd0);
        repeat (5) tick();

        // held request while enable rises must not fire
        bk_ena = 1'b0;
        tick();
        save_req = 1'b1;
        repeat (3) tick();
        bk_ena = 1'b1;
        repeat (10) tick();
        chk("ena_edge_idle", 64'(bk_state), 64'd0);
        save_req = 1'b0;
        repeat (3) tick();

        // autosave after holdoff
        slot = 2'd3;
        autosave_en = 1'b1;
        push_exp(1'b1, 3);
        dirty_set = 1'b1;
        tick();
        dirty_set = 1'b0;
        repeat (49) tick();
        dirty_set = 1'b1;
        tick();
        dirty_set = 1'b0;
        repeat (100) tick();
        chk("auto_early", 64'(bk_state), 64'd0);
        tick();
        chk("auto_start", 64'(bk_state), 64'd1);
        run_xfer(1'b0, nd, lb);
        chk("auto_done", 64'(nd), 64'd1);
        repeat (150) tick();
        chk("auto_clean", 64'(bk_state), 64'd0);
        autosave_en = 1'b0;

        // watchdog: sector 5 never acked
        slot = 2'd2;
        hang_en = 1'b1;
        push_exp(1'b1, 2);
        pulse(1'b0, 1'b1);
        wait_wr_sector(6'd5);
        repeat (19) tick();
        chk("wd_wr_hold", 64'(sd_wr), 64'd1);
        tick();
        chk("wd_wr_drop", 64'(sd_wr), 64'd0);
        chk("wd_err", 64'(err), 64'd1);
        chk("wd_state", 64'(bk_state), 64'd0);
        chk("wd_nodone", 64'(done), 64'd0);
        hang_en = 1'b0;
        repeat (10) tick();
        exp_q.delete();
        push_exp(1'b1, 2);
        pulse(1'b0, 1'b1);
        chk("wd_err_clr", 64'(err), 64'd0);
        run_xfer(1'b0, nd, lb);
        chk("wd_retry_done", 64'(nd), 64'd1);
        repeat (5) tick();

        // enable loss during sector 10
        slot = 2'd1;
        push_exp(1'b1, 1);
        w0 = wr_cnt;
        pulse(1'b0, 1'b1);
        wait_wr_sector(6'd10);
        bk_ena = 1'b0;
        run_xfer(1'b0, nd, lb);
        chk("ena_nodone", 64'(nd), 64'd0);
        chk("ena_err", 64'(err), 64'd1);
        chk("ena_state", 64'(bk_state), 64'd0);
        repeat (20) tick();
        chk("ena_wr", 64'(wr_cnt - w0), 64'd11);
        exp_q.delete();
        bk_ena = 1'b1;
        repeat (5) tick();

        // async reset mid-transfer
        slot = 2'd0;
        push_exp(1'b1, 0);
        pulse(1'b0, 1'b1);
        wait_wr_sector(6'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_wr", 64'(sd_wr), 64'd0);
        chk("arst_state", 64'(bk_state), 64'd0);
        repeat (20) tick();
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
